// File: rtl/tile_flash_drawer.sv
// Paints an 8x8 tile into the VGA plot port one pixel per clock, holds it lit,
// then optionally repaints it in the erase colour.
module tile_flash_drawer #(
  parameter int          HOLD_CYCLES  = 25000000,
  parameter int          HOLD_W       = 25,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       erase_en,
  input  logic [7:0] tile_x,
  input  logic [7:0] tile_y,
  input  logic [2:0] tile_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  // state   | meaning
  // S_IDLE  | waiting for start, outputs parked at 0
  // S_DRAW  | scanning 64 pixels in the tile colour
  // S_HOLD  | tile lit, hold timer running
  // S_ERASE | scanning 64 pixels in the erase colour
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_HOLD,
    S_ERASE,
    S_DONE
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t            state, state_nxt;
  logic [5:0]        cnt, cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [7:0]        base_x;
  logic [6:0]        base_y;
  logic [2:0]        base_colour;
  logic              erase_lat;
  logic              tile_y_unused;

  // The VGA adapter is only 120 rows tall; the top y bit never reaches it.
  assign tile_y_unused = tile_y[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hold_cnt    <= '0;
      base_x      <= '0;
      base_y      <= '0;
      base_colour <= '0;
      erase_lat   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hold_cnt <= hold_nxt;
      if (state == S_IDLE && start) begin
        base_x      <= tile_x;
        base_y      <= tile_y[6:0];
        base_colour <= tile_colour;
        erase_lat   <= erase_en;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hold_nxt   = hold_cnt;
    plot       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_DRAW;
          cnt_nxt   = '0;
        end
      end

      S_DRAW: begin
        plot       = 1'b1;
        vga_x      = base_x + {5'b0, cnt[2:0]};
        vga_y      = base_y + {4'b0, cnt[5:3]};
        vga_colour = base_colour;
        cnt_nxt    = cnt + 6'd1;
        if (cnt == 6'd63) begin
          if (HOLD_CYCLES > 0) begin
            state_nxt = S_HOLD;
            hold_nxt  = '0;
          end else if (erase_lat) begin
            state_nxt = S_ERASE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end

      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = erase_lat ? S_ERASE : S_DONE;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end

      S_ERASE: begin
        plot       = 1'b1;
        vga_x      = base_x + {5'b0, cnt[2:0]};
        vga_y      = base_y + {4'b0, cnt[5:3]};
        vga_colour = ERASE_COLOUR;
        cnt_nxt    = cnt + 6'd1;
        if (cnt == 6'd63) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tile_flash_drawer.sv
// Self-checking bench for tile_flash_drawer: two instances (hold of 4 and of 0)
// compared cycle by cycle against a per-cycle expectation list built from the flash rules.
module tb_tile_flash_drawer;

  localparam int H4 = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, erase_en = 1'b0, sel = 1'b0;
  logic [7:0] tile_x = '0, tile_y = '0;
  logic [2:0] tile_colour = '0;
  logic       start4, start0;
  assign start4 = start & ~sel;
  assign start0 = start & sel;

  logic [7:0] x4, x0, o_x;
  logic [6:0] y4, y0, o_y;
  logic [2:0] c4, c0, o_c;
  logic       plot4, plot0, busy4, busy0, done4, done0;
  logic       o_plot, o_busy, o_done;

  assign o_x    = sel ? x0 : x4;
  assign o_y    = sel ? y0 : y4;
  assign o_c    = sel ? c0 : c4;
  assign o_plot = sel ? plot0 : plot4;
  assign o_busy = sel ? busy0 : busy4;
  assign o_done = sel ? done0 : done4;

  tile_flash_drawer #(.HOLD_CYCLES(H4), .HOLD_W(3), .ERASE_COLOUR(3'b000)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .erase_en(erase_en),
    .tile_x(tile_x), .tile_y(tile_y), .tile_colour(tile_colour),
    .vga_x(x4), .vga_y(y4), .vga_colour(c4),
    .plot(plot4), .busy(busy4), .done(done4));

  tile_flash_drawer #(.HOLD_CYCLES(0), .HOLD_W(1), .ERASE_COLOUR(3'b000)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .erase_en(erase_en),
    .tile_x(tile_x), .tile_y(tile_y), .tile_colour(tile_colour),
    .vga_x(x0), .vga_y(y0), .vga_colour(c0),
    .plot(plot0), .busy(busy0), .done(done0));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit plot;
    bit busy;
    bit done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t expq[$];

  // Expected outputs for cycles 1..N+1 after the accepting edge (last entry is IDLE).
  function automatic void build(int x, int y, int c, bit e, int h);
    expq.delete();
    for (int p = 0; p < 64; p++)
      expq.push_back('{1'b1, 1'b1, 1'b0, (x + p % 8) % 256, (y % 128 + p / 8) % 128, c});
    for (int i = 0; i < h; i++)
      expq.push_back('{1'b0, 1'b1, 1'b0, 0, 0, 0});
    if (e)
      for (int p = 0; p < 64; p++)
        expq.push_back('{1'b1, 1'b1, 1'b0, (x + p % 8) % 256, (y % 128 + p / 8) % 128, 0});
    expq.push_back('{1'b0, 1'b1, 1'b1, 0, 0, 0});
    expq.push_back('{1'b0, 1'b0, 1'b0, 0, 0, 0});
  endfunction

  task automatic run_flash(input string tag, input int x, input int y, input int c,
                           input bit e, input bit use0, input bit junk,
                           input bit chained, input bit keep_start);
    int   n;
    exp_t ex;
    build(x, y, c, e, use0 ? 0 : H4);
    n = expq.size();
    if (!chained) @(negedge clk);
    sel         = use0;
    tile_x      = 8'(x);
    tile_y      = 8'(y);
    tile_colour = 3'(c);
    erase_en    = e;
    start       = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      ex = expq[k-1];
      vectors++;
      if ({o_plot, o_busy, o_done} !== {ex.plot, ex.busy, ex.done}) begin
        miscompares++;
        if (miscompares <= 40)
          $display("FAIL %s cyc %0d ctl got plot=%0b busy=%0b done=%0b want plot=%0b busy=%0b done=%0b",
                   tag, k, o_plot, o_busy, o_done, ex.plot, ex.busy, ex.done);
      end
      if (ex.plot || k == n) begin
        vectors++;
        if (o_x !== 8'(ex.x) || o_y !== 7'(ex.y) || o_c !== 3'(ex.c)) begin
          miscompares++;
          if (miscompares <= 40)
            $display("FAIL %s cyc %0d pix got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                     tag, k, o_x, o_y, o_c, ex.x, ex.y, ex.c);
        end
      end
      if (k == n - 1) begin
        start = keep_start;
      end else if (k < n - 1) begin
        if (junk) begin
          start       = 1'($urandom);
          tile_x      = 8'($urandom);
          tile_y      = 8'($urandom);
          tile_colour = 3'($urandom);
          erase_en    = 1'($urandom);
        end else if (k == 1) begin
          start = keep_start;
        end
      end
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({plot4, busy4, done4, x4, y4, c4, plot0, busy0, done0} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs got p=%0b b=%0b d=%0b x=%0d y=%0d c=%0d want all 0",
               plot4, busy4, done4, x4, y4, c4);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({plot4, busy4, done4, plot0, busy0, done0} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle got busy4=%0b busy0=%0b want 0", busy4, busy0);
    end
  endtask

  task automatic test_basic;
    run_flash("erase_x8", 8, 0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_flash("noerase_y8", 0, 8, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_hold;
    run_flash("h0_erase", 8, 8, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_flash("h0_noerase", 16, 40, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start;
    run_flash("busy_junk", 40, 24, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_flash("busy_junk_h0", 72, 56, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_flash("b2b_0", 0, 0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_flash("b2b_1", 100, 50, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_flash("b2b_2", 200, 100, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    sel = 1'b0; tile_x = 8'd32; tile_y = 8'd16; tile_colour = 3'b111; erase_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    vectors++;
    if (plot4 !== 1'b1 || x4 !== 8'd36 || y4 !== 7'd18) begin
      miscompares++;
      $display("FAIL areset_pre got plot=%0b x=%0d y=%0d want plot=1 x=36 y=18", plot4, x4, y4);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({plot4, busy4, done4, x4, y4, c4} !== '0) begin
      miscompares++;
      $display("FAIL areset_now got p=%0b b=%0b d=%0b x=%0d y=%0d c=%0d want all 0",
               plot4, busy4, done4, x4, y4, c4);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({plot4, busy4, done4} !== 3'b000) begin
        miscompares++;
        $display("FAIL areset_after got p=%0b b=%0b d=%0b want 000", plot4, busy4, done4);
      end
    end
    run_flash("after_reset", 32, 16, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap;
    run_flash("wrap", 252, 125, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_flash("wrap_h0", 255, 255, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_flash("random", int'($urandom_range(255)), int'($urandom_range(255)),
                int'($urandom_range(7)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_no_hold;
    test_ignore_start;
    test_back_to_back;
    test_async_reset;
    test_wrap;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tile_flash_drawer.md
# tile_flash_drawer

Downstream consumer of the tile coordinate/colour lookup: takes a tile's top-left pixel (x, y) and colour, paints the 8×8 tile square into the VGA adapter one pixel per clock, holds it lit for a programmable time, then optionally repaints it in the background colour. It sits between the sequence/playback controller, which supplies the tile lookup outputs plus a start strobe, and the VGA adapter's plot port. It gives the game its "tile flash" primitive.

## Interface
Parameters:
- HOLD_CYCLES, 25000000, number of clocks the tile stays lit between paint and erase (0.5 s at 50 MHz); 0 means no hold
- HOLD_W, 25, width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES
- ERASE_COLOUR, 3'b000, colour written during the erase pass

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a flash; sampled only in IDLE
- erase_en  in  1  1 = erase after hold, 0 = leave tile painted; latched with start
- tile_x  in  8  tile top-left x, from tile lookup
- tile_y  in  8  tile top-left y, from tile lookup; only bits [6:0] used
- tile_colour  in  3  paint colour, from tile lookup
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- vga_colour  out  3  pixel colour to VGA adapter
- plot  out  1  write-enable to VGA adapter
- busy  out  1  high while a flash is in progress
- done  out  1  one-cycle pulse when the flash completes

## Operation
- States: IDLE, DRAW, HOLD, ERASE, DONE.
- IDLE: plot=0, busy=0. If start=1 at a clock edge: latch tile_x, tile_y[6:0], tile_colour, erase_en; clear pixel counter; go to DRAW. tile_* inputs are ignored at all other times.
- DRAW: plot=1; 6-bit pixel counter cnt, cnt[2:0] = column offset, cnt[5:3] = row offset. vga_x = base_x + cnt[2:0], vga_y = base_y + cnt[5:3], modulo 2^8 and 2^7 (no saturation, wrap is allowed). vga_colour = latched colour. Increment cnt every cycle; after cnt=63 go to HOLD (HOLD_CYCLES>0), else to ERASE if erase_en, else DONE.
- HOLD: plot=0; hold counter counts 0..HOLD_CYCLES-1, then go to ERASE if latched erase_en=1, else DONE.
- ERASE: identical scan to DRAW (cnt restarts at 0), vga_colour = ERASE_COLOUR; after cnt=63 go to DONE.
- DONE: done=1, busy=1, plot=0 for exactly one cycle, then IDLE.
- start asserted while busy: ignored, not queued. start held high continuously: a new flash begins on the first IDLE cycle after DONE.
- vga_x/vga_y/vga_colour are don't-care when plot=0, but are driven to 0 in IDLE.

## Timing
- Reset (asynchronous, any state): state=IDLE, cnt=0, hold counter=0, plot=0, busy=0, done=0, vga_x=0, vga_y=0, vga_colour=0, latched regs=0. Reset mid-DRAW/ERASE aborts immediately; no further plot pulses.
- Outputs are decoded from registered state/counters: valid in the same cycle as plot.
- Edge E0 accepts start; cycles 1..64 are DRAW (pixel k on cycle k+1), cycles 65..64+H are HOLD (H=HOLD_CYCLES), cycles 65+H..128+H are ERASE, cycle 129+H is DONE (done=1), cycle 130+H is IDLE, where a new start can be accepted. With erase_en=0: DONE at cycle 65+H.
- busy is high from cycle 1 through the DONE cycle inclusive.
- Exactly 64 plot cycles per pass; no gaps within a pass.

## Test plan
- Reset then HOLD_CYCLES=4, start with x=8, y=0, colour=3'b010, erase_en=1 -> 64 plots (8..15, 0..7) in row-major order with colour 010, 4 idle cycles, 64 plots with colour 000, done pulse at cycle 133, busy low at cycle 134.
- erase_en=0, x=0, y=8, colour=3'b011, HOLD_CYCLES=4 -> 64 plots covering (0..7, 8..15), done at cycle 69, no erase pass.
- HOLD_CYCLES=0, x=8, y=8, colour=3'b100 -> ERASE starts at cycle 65, immediately after cnt=63; done at cycle 129.
- start pulsed at cycles 10 and 70 during a flash, tile inputs changed mid-flash -> no effect on coordinates/colour, single done pulse; start held high -> back-to-back flashes, each start accepted on the first IDLE cycle.
- Reset asserted asynchronously at DRAW pixel 20 -> plot, busy, done and vga_* go to 0 without waiting for a clock edge; after release, state is IDLE and a fresh start draws from pixel 0.
- x=252, y=125 -> vga_x wraps to 0..3 and vga_y wraps to 0..4 modulo their widths; still 64 plots.
